memory_access: RTL

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// Memory-access stage: issues data-memory requests for loads/stores, holds them stable
// across wait states, and registers the writeback bundle (MW_*) every cycle.
module memory_access #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic [2:0]          ED_load_op_i,
  input  logic [1:0]          ED_store_op_i,
  input  logic [XLEN-1:0]     ED_valE_i,
  input  logic [XLEN-1:0]     ED_rs2_data_i,
  input  logic                ED_need_dstE_i,
  input  logic [4:0]          ED_dstE_i,
  input  logic [PC_WIDTH-1:0] ED_PC_i,
  input  logic                ED_commit_i,
  output logic                dm_req_o,
  output logic                dm_we_o,
  output logic [XLEN-1:0]     dm_addr_o,
  output logic [XLEN-1:0]     dm_wdata_o,
  output logic [3:0]          dm_wstrb_o,
  input  logic                dm_ack_i,
  input  logic [XLEN-1:0]     dm_rdata_i,
  output logic                M_stall_o,
  output logic                M_misalign_o,
  output logic [XLEN-1:0]     MW_valW_o,
  output logic                MW_need_dstE_o,
  output logic [4:0]          MW_dstE_o,
  output logic [PC_WIDTH-1:0] MW_PC_o,
  output logic                MW_commit_o
);

  localparam logic [2:0] LD_NONE = 3'd0, LD_LB = 3'd1, LD_LH = 3'd2, LD_LW = 3'd3,
                         LD_LBU  = 3'd4, LD_LHU = 3'd5;
  localparam logic [1:0] ST_NONE = 2'd0, ST_SB = 2'd1, ST_SH = 2'd2;
  localparam logic [0:0] S_IDLE = 1'b0, S_WAIT = 1'b1;

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] op, input logic [1:0] lo,
                                               input logic [XLEN-1:0] word);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h  = lo[1] ? word[31:16] : word[15:0];
    bs = $signed(b);
    hs = $signed(h);
    case (op)
      LD_LB:   load_ext = XLEN'(bs);
      LD_LH:   load_ext = XLEN'(hs);
      LD_LBU:  load_ext = XLEN'(b);
      LD_LHU:  load_ext = XLEN'(h);
      default: load_ext = word;
    endcase
  endfunction

  logic [0:0]          state_q;
  logic                ld_any, st_any, misalign_d, mem_op_d, misalign_ev_d;
  logic [XLEN-1:0]     st_wdata_d;
  logic [3:0]          st_wstrb_d;
  logic [XLEN-1:0]     addr_p0, wdata_p0;
  logic [3:0]          wstrb_p0;
  logic                we_p0, need_p0;
  logic [2:0]          ld_op_p0;
  logic [4:0]          dst_p0;
  logic [PC_WIDTH-1:0] pc_p0;
  logic                in_wait, active, complete, cur_we, cur_need;
  logic [XLEN-1:0]     cur_addr, cur_wdata;
  logic [3:0]          cur_wstrb;
  logic [2:0]          cur_ld_op;
  logic [4:0]          cur_dst;
  logic [PC_WIDTH-1:0] cur_pc;
  logic                vld_p1, need_p1, misalign_p1;
  logic [XLEN-1:0]     valw_p1;
  logic [4:0]          dst_p1;
  logic [PC_WIDTH-1:0] pc_p1;

  // Decode of the incoming ED instruction; a store field wins over a load field.
  always_comb begin
    ld_any     = (ED_load_op_i >= LD_LB) && (ED_load_op_i <= LD_LHU);
    st_any     = ED_store_op_i != ST_NONE;
    misalign_d = 1'b0;
    st_wdata_d = '0;
    st_wstrb_d = 4'b0000;
    if (st_any) begin
      case (ED_store_op_i)
        ST_SB: begin
          st_wstrb_d = 4'b0001 << ED_valE_i[1:0];
          st_wdata_d = XLEN'({4{ED_rs2_data_i[7:0]}});
        end
        ST_SH: begin
          st_wstrb_d = ED_valE_i[1] ? 4'b1100 : 4'b0011;
          st_wdata_d = XLEN'({2{ED_rs2_data_i[15:0]}});
          misalign_d = ED_valE_i[0];
        end
        default: begin
          st_wstrb_d = 4'b1111;
          st_wdata_d = ED_rs2_data_i;
          misalign_d = |ED_valE_i[1:0];
        end
      endcase
    end else if (ld_any) begin
      case (ED_load_op_i)
        LD_LH, LD_LHU: misalign_d = ED_valE_i[0];
        LD_LW:         misalign_d = |ED_valE_i[1:0];
        default:       misalign_d = 1'b0;
      endcase
    end
    mem_op_d      = ED_commit_i && (ld_any || st_any) && !misalign_d;
    misalign_ev_d = ED_commit_i && misalign_d;
  end

  // Request source: live ED fields in IDLE, latched copy while waiting.
  always_comb begin
    in_wait   = state_q == S_WAIT;
    cur_addr  = in_wait ? addr_p0  : ED_valE_i;
    cur_we    = in_wait ? we_p0    : st_any;
    cur_wdata = in_wait ? wdata_p0 : st_wdata_d;
    cur_wstrb = in_wait ? wstrb_p0 : st_wstrb_d;
    cur_ld_op = in_wait ? ld_op_p0 : (st_any ? LD_NONE : ED_load_op_i);
    cur_dst   = in_wait ? dst_p0   : ED_dstE_i;
    cur_need  = in_wait ? need_p0  : ED_need_dstE_i;
    cur_pc    = in_wait ? pc_p0    : ED_PC_i;
    active    = rst_n && (in_wait || mem_op_d);
    complete  = active && dm_ack_i;
  end

  assign dm_req_o   = active;
  assign dm_we_o    = active && cur_we;
  assign dm_addr_o  = active ? {cur_addr[XLEN-1:2], 2'b00} : '0;
  assign dm_wdata_o = active ? cur_wdata : '0;
  assign dm_wstrb_o = active ? cur_wstrb : 4'b0000;
  assign M_stall_o  = active && !dm_ack_i;

  // p0: request latch and IDLE/WAIT control
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      wstrb_p0 <= 4'b0000;
      we_p0    <= 1'b0;
      need_p0  <= 1'b0;
      ld_op_p0 <= LD_NONE;
      dst_p0   <= 5'd0;
      pc_p0    <= '0;
    end else begin
      case (state_q)
        S_IDLE:  if (mem_op_d && !dm_ack_i) state_q <= S_WAIT;
        S_WAIT:  if (dm_ack_i) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (!in_wait && mem_op_d) begin
        addr_p0  <= ED_valE_i;
        wdata_p0 <= st_wdata_d;
        wstrb_p0 <= st_wstrb_d;
        we_p0    <= st_any;
        need_p0  <= ED_need_dstE_i;
        ld_op_p0 <= cur_ld_op;
        dst_p0   <= ED_dstE_i;
        pc_p0    <= ED_PC_i;
      end
    end
  end

  // p1: writeback bundle, reloaded every edge (result, pass-through or bubble)
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      need_p1     <= 1'b0;
      valw_p1     <= '0;
      dst_p1      <= 5'd0;
      pc_p1       <= '0;
      misalign_p1 <= 1'b0;
    end else begin
      misalign_p1 <= !in_wait && misalign_ev_d;
      if (complete) begin
        vld_p1  <= 1'b1;
        need_p1 <= !cur_we && cur_need;
        valw_p1 <= cur_we ? '0 : load_ext(cur_ld_op, cur_addr[1:0], dm_rdata_i);
        dst_p1  <= cur_dst;
        pc_p1   <= cur_pc;
      end else if (!in_wait && ED_commit_i && !mem_op_d && !misalign_ev_d) begin
        vld_p1  <= 1'b1;
        need_p1 <= ED_need_dstE_i;
        valw_p1 <= ED_valE_i;
        dst_p1  <= ED_dstE_i;
        pc_p1   <= ED_PC_i;
      end else begin
        vld_p1  <= 1'b0;
        need_p1 <= 1'b0;
        valw_p1 <= '0;
        dst_p1  <= 5'd0;
        pc_p1   <= '0;
      end
    end
  end

  assign MW_commit_o    = vld_p1;
  assign MW_need_dstE_o = need_p1;
  assign MW_valW_o      = valw_p1;
  assign MW_dstE_o      = dst_p1;
  assign MW_PC_o        = pc_p1;
  assign M_misalign_o   = misalign_p1;

endmodule
